// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - sequential scanner driving a 4:1 mux select and packing sampled Y bits
module mux_scan_sequencer #(
  parameter int DWELL = 2,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] ch_mask,
  input  logic       mux_y,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       done,
  output logic [3:0] samples
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [3:0]         mask, mask_n;
  logic [1:0]         sel_n;
  logic               busy_n, done_n;
  logic [3:0]         samples_n;
  logic [2:0]         pick;

  // {found, index} of the lowest enabled channel at or above 'from'
  function automatic logic [2:0] next_ch(input logic [3:0] m, input int from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && i >= from) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mask    <= 4'h0;
      mux_sel <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      samples <= 4'h0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      mask    <= mask_n;
      mux_sel <= sel_n;
      busy    <= busy_n;
      done    <= done_n;
      samples <= samples_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mask_n    = mask;
    sel_n     = mux_sel;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    samples_n = samples;
    pick      = 3'b000;
    case (state)
      IDLE: begin
        sel_n = 2'b00;
        if (start) begin
          mask_n    = ch_mask;
          samples_n = 4'h0;
          cnt_n     = '0;
          pick      = next_ch(ch_mask, 0);
          if (pick[2]) begin
            state_n = SCAN;
            sel_n   = pick[1:0];
            busy_n  = 1'b1;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
      SCAN: begin
        // abort beats a coinciding capture edge
        if (abort) begin
          state_n = IDLE;
          sel_n   = 2'b00;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(DWELL - 1)) begin
          samples_n[mux_sel] = mux_y;
          cnt_n = '0;
          pick  = next_ch(mask, int'(mux_sel) + 1);
          if (pick[2]) begin
            sel_n  = pick[1:0];
            busy_n = 1'b1;
          end else begin
            state_n = DONE;
            sel_n   = 2'b00;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n  = cnt + CNT_W'(1);
          busy_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        sel_n   = 2'b00;
      end
      default: begin
        state_n = IDLE;
        sel_n   = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - scoreboard bench for mux_scan_sequencer with a behavioural 4:1 mux
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, mux_y;
  logic [3:0] ch_mask, data;
  logic [1:0] mux_sel;
  logic       busy, done;
  logic [3:0] samples;

  mux_scan_sequencer #(.DWELL(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_mask(ch_mask),
    .mux_y(mux_y), .mux_sel(mux_sel), .busy(busy), .done(done), .samples(samples)
  );

  always #5 clk = ~clk;
  assign mux_y = data[mux_sel];

  typedef struct packed {
    logic [3:0]  smp;
    int          nbusy;
    logic [15:0] trace;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          busy_cnt = 0;
  logic [15:0] trace = 16'h0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: accumulates busy length and select trace, scores on done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        trace = (trace << 2) | 16'(mux_sel);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("samples", int'(samples), int'(e.smp));
          check("busy_cycles", busy_cnt, e.nbusy);
          check("sel_trace", int'(trace), int'(e.trace));
        end
        busy_cnt = 0;
        trace    = 16'h0;
      end else if (!busy) begin
        busy_cnt = 0;
        trace    = 16'h0;
      end
    end
  end

  task automatic run_scan(input logic [3:0] mask, input logic [3:0] d, input logic [3:0] exp_smp,
                          input int exp_busy, input logic [15:0] exp_trace,
                          input bit poke, input bit with_abort);
    int lat;
    data = d;
    sb.push_back('{exp_smp, exp_busy, exp_trace});
    @(negedge clk);
    ch_mask = mask;
    start   = 1'b1;
    abort   = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    lat   = 1;
    while (!done && lat < 30) begin
      start = poke && (lat == 3);
      if (poke && lat == 3) ch_mask = 4'h0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_latency", lat, exp_busy + 1);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("sel_after_done", int'(mux_sel), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ch_mask = 4'h0; data = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_sel", int'(mux_sel), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_samples", int'(samples), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // A=0,B=1,C=0,D=1 full mask
    run_scan(4'hF, 4'b1010, 4'b1010, 8, 16'h05AF, 0, 0);
    // inverse pattern, with an ignored start/mask change mid-scan
    run_scan(4'hF, 4'b0101, 4'b0101, 8, 16'h05AF, 1, 0);
    // sparse mask skips channels 0 and 2
    run_scan(4'b1010, 4'hF, 4'b1010, 4, 16'h005F, 0, 0);
    // empty mask goes straight to DONE
    run_scan(4'h0, 4'hF, 4'h0, 0, 16'h0000, 0, 0);

    // abort at E3 keeps samples[0]
    data = 4'hF;
    @(negedge clk); ch_mask = 4'hF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_samples", int'(samples), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_sel", int'(mux_sel), 0);
    check("abort_done", int'(done), 0);
    // start together with abort in IDLE is accepted
    run_scan(4'hF, 4'hF, 4'hF, 8, 16'h05AF, 0, 1);

    // abort on a capture edge suppresses the capture
    @(negedge clk); ch_mask = 4'hF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_edge_samples", int'(samples), 0);
    check("abort_edge_busy", int'(busy), 0);

    // async reset mid-scan
    data = 4'b1010;
    @(negedge clk); ch_mask = 4'hF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_samples", int'(samples), 2);
    check("pre_reset_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sel", int'(mux_sel), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_samples", int'(samples), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_scan(4'hF, 4'b1010, 4'b1010, 8, 16'h05AF, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
